// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester with wait-state timeout
module apb_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);
   localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO = CW'(TIMEOUT);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  to_q, to_d;
   logic                  accept, done, abort;

   // next-state: handshake, APB phase sequencing, wait counting and response capture
   always_comb begin
      accept  = state_q == IDLE && cmd_valid;
      done    = state_q == ACCESS && PREADY;
      abort   = state_q == ACCESS && !PREADY && TIMEOUT != 0 && cnt_q == TO;
      state_d = accept ? SETUP :
                state_q == SETUP ? ACCESS :
                (state_q == ACCESS && !done && !abort) ? ACCESS :
                (state_q == IDLE) ? IDLE : IDLE;
      cnt_d   = accept ? '0 : (state_q == ACCESS && !PREADY) ? cnt_q + 1'b1 : cnt_q;
      addr_d  = accept ? cmd_addr : addr_q;
      write_d = accept ? cmd_write : write_q;
      wdata_d = accept ? cmd_wdata : wdata_q;
      valid_d = done || abort;
      rdata_d = done ? (write_q ? '0 : PRDATA) : abort ? '0 : rdata_q;
      err_d   = done ? PSLVERR : abort ? 1'b1 : err_q;
      to_d    = done ? 1'b0 : abort ? 1'b1 : to_q;
   end

   // state and output registers; reset drops any transfer in flight
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         valid_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         valid_q <= valid_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         to_q    <= to_d;
      end
   end

   assign cmd_ready   = state_q == IDLE && !PRESET;
   assign PSEL        = state_q == SETUP || state_q == ACCESS;
   assign PENABLE     = state_q == ACCESS;
   assign PADDR       = addr_q;
   assign PWRITE      = write_q;
   assign PWDATA      = wdata_q;
   assign rsp_valid   = valid_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;
   assign rsp_timeout = to_q;
endmodule
